perm_output_interface: RTL and testbench

// - Output stage of perm; sits directly downstream of perm_logic. Captures the 1600-bit Keccak state on

---
 rtl/perm_output_interface.sv | 155 +++++++++++++++
 tb/tb_perm_output_interface.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/perm_output_interface.sv
// Output stage of perm: buffers up to DEPTH captured 1600-bit states and
// streams each one out as NBEATS registered beats tagged with a beat index.
module perm_output_interface #(
  parameter int BEAT_W = 200,
  parameter int NBEATS = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BEAT_W*NBEATS-1:0] statein,
  input  logic                     pushin,
  output logic [2:0]               doutix,
  output logic [BEAT_W-1:0]        dout,
  output logic                     pushout,
  output logic                     busy,
  output logic                     overflow
);

  localparam int STATE_W = BEAT_W * NBEATS;
  localparam int IX_W    = 3;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  localparam logic [IX_W-1:0]  LAST_IX  = IX_W'(NBEATS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } fsm_e;

  fsm_e               state_q;
  logic [IX_W-1:0]    cnt_q;
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [OCC_W-1:0]   occ_q;
  logic [OCC_W-1:0]   occ_d;
  logic [IX_W-1:0]    doutix_q;
  logic [BEAT_W-1:0]  dout_q;
  logic               pushout_q;
  logic               overflow_q;

  logic [STATE_W-1:0] mem_q [DEPTH];
  logic [STATE_W-1:0] head_entry_s;
  logic [BEAT_W-1:0]  beat_s;
  logic               load_s;
  logic               pop_s;
  logic               accept_s;
  logic               drop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Beat selection, pop/accept decisions and next occupancy.
  always_comb begin
    load_s       = 1'b0;
    pop_s        = 1'b0;
    head_entry_s = mem_q[head_q];
    case (state_q)
      S_IDLE: begin
        load_s = (occ_q != '0);
        pop_s  = 1'b0;
      end
      S_SEND: begin
        load_s = 1'b1;
        pop_s  = (cnt_q == LAST_IX);
      end
      default: begin
        load_s = 1'b0;
        pop_s  = 1'b0;
      end
    endcase
    // A pop on this edge frees the head slot, so a full buffer can still accept.
    accept_s = pushin & ((occ_q != FULL_OCC) | pop_s);
    drop_s   = pushin & ~accept_s;
    occ_d    = occ_q + OCC_W'(accept_s) - OCC_W'(pop_s);
    beat_s   = head_entry_s[cnt_q*BEAT_W +: BEAT_W];
  end

  // State buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[tail_q] <= statein;
    end
  end

  // Sequencer FSM, buffer pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      doutix_q   <= '0;
      dout_q     <= '0;
      pushout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (accept_s) begin
        tail_q <= ptr_inc(tail_q);
      end
      if (pop_s) begin
        head_q <= ptr_inc(head_q);
      end
      if (drop_s) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (load_s) begin
            state_q   <= S_SEND;
            dout_q    <= beat_s;
            doutix_q  <= cnt_q;
            pushout_q <= 1'b1;
            cnt_q     <= cnt_q + IX_W'(1);
          end else begin
            pushout_q <= 1'b0;
          end
        end
        S_SEND: begin
          dout_q    <= beat_s;
          doutix_q  <= cnt_q;
          pushout_q <= 1'b1;
          if (pop_s) begin
            cnt_q <= '0;
            if (occ_d == '0) begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + IX_W'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          pushout_q <= 1'b0;
        end
      endcase
    end
  end

  assign doutix   = doutix_q;
  assign dout     = dout_q;
  assign pushout  = pushout_q;
  assign overflow = overflow_q;
  assign busy     = (occ_q != '0) | pushout_q;

endmodule

// File: tb/tb_perm_output_interface.sv
// Directed bench for perm_output_interface: lane map, back-to-back, overflow,
// pop/push collision, mid-frame reset and beat reassembly.
module tb_perm_output_interface;

  logic           clk;
  logic           reset;
  logic [1599:0]  statein;
  logic           pushin;
  logic [2:0]     doutix;
  logic [199:0]   dout;
  logic           pushout;
  logic           busy;
  logic           overflow;

  int total;
  int bad;
  int cyc;

  logic [2:0]    ix_q  [$];
  logic [199:0]  dat_q [$];
  int            cyc_q [$];
  logic          ov_q  [$];
  logic [1599:0] exp_q [$];

  perm_output_interface dut (
    .clk      (clk),
    .reset    (reset),
    .statein  (statein),
    .pushin   (pushin),
    .doutix   (doutix),
    .dout     (dout),
    .pushout  (pushout),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] make_state(input int seed);
    logic [1599:0] s;
    logic [63:0] lane;
    for (int l = 0; l < 25; l++) begin
      lane = 64'h0101_0101_0101_0101 * 64'(l);
      lane = lane ^ (64'(seed) * 64'h9E37_79B9_7F4A_7C15);
      s[64*l +: 64] = lane;
    end
    return s;
  endfunction

  // Sample outputs of the previous edge, then drive inputs for the next edge.
  task automatic step(input logic p, input logic [1599:0] s);
    @(negedge clk);
    if (pushout) begin
      ix_q.push_back(doutix);
      dat_q.push_back(dout);
      cyc_q.push_back(cyc);
    end
    ov_q.push_back(overflow);
    pushin  = p;
    statein = s;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic clear_logs();
    ix_q.delete();
    dat_q.delete();
    cyc_q.delete();
    ov_q.delete();
    exp_q.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b0;
    pushin = 1'b0;
    #1;
    check_val("rst_pushout", 200'(pushout), 200'd0);
    check_val("rst_overflow", 200'(overflow), 200'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic check_frames(input string tag, input int nframes, input int first_cyc);
    logic [1599:0] st;
    check_val({tag, "_nbeats"}, 200'(ix_q.size()), 200'(nframes * 8));
    if (ix_q.size() > 0) check_val({tag, "_latency"}, 200'(cyc_q[0]), 200'(first_cyc));
    for (int i = 0; i < ix_q.size() && i < nframes * 8; i++) begin
      st = exp_q[i / 8];
      check_val({tag, "_ix"}, 200'(ix_q[i]), 200'(i % 8));
      check_val({tag, "_data"}, dat_q[i], st[(i % 8) * 200 +: 200]);
      check_val({tag, "_nogap"}, 200'(cyc_q[i]), 200'(first_cyc + i));
    end
  endtask

  initial begin
    logic [1599:0] st;
    logic [1599:0] rebuilt;
    logic [199:0]  b;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    pushin  = 1'b0;
    statein = '0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_val("reset_doutix", 200'(doutix), 200'd0);
    check_val("reset_dout", dout, 200'd0);
    check_val("reset_pushout", 200'(pushout), 200'd0);
    check_val("reset_busy", 200'(busy), 200'd0);
    check_val("reset_overflow", 200'(overflow), 200'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();

    // Lane map, single state, plus reassembly as a loopback consumer would do.
    st = make_state(0);
    exp_q.push_back(st);
    step(1'b1, st);
    idle(14);
    check_frames("lanemap", 1, 2);
    if (dat_q.size() >= 8) begin
      b = dat_q[0];
      check_val("lane_b0_lane1", 200'(b[127:64]), 200'h0101_0101_0101_0101);
      check_val("lane_b0_byte", 200'(b[199:192]), 200'h03);
      b = dat_q[7];
      check_val("lane_b7_lane24", 200'(b[199:136]), 200'h1818_1818_1818_1818);
      rebuilt = '0;
      for (int i = 0; i < 8; i++) rebuilt[200 * ix_q[i] +: 200] = dat_q[i];
      check_val("loopback_state", 200'(rebuilt == st), 200'd1);
    end
    check_val("lane_busy_end", 200'(busy), 200'd0);

    // Back-to-back states at cycles 0 and 8.
    do_reset();
    exp_q.push_back(make_state(1));
    exp_q.push_back(make_state(2));
    step(1'b1, exp_q[0]);
    idle(7);
    step(1'b1, exp_q[1]);
    idle(14);
    check_frames("b2b", 2, 2);
    check_val("b2b_overflow", 200'(overflow), 200'd0);

    // Overflow: third push into a full buffer is dropped.
    do_reset();
    exp_q.push_back(make_state(3));
    exp_q.push_back(make_state(4));
    step(1'b1, exp_q[0]);
    step(1'b1, exp_q[1]);
    step(1'b1, make_state(5));
    idle(24);
    check_frames("ovf", 2, 2);
    check_val("ovf_cyc2", 200'(ov_q[2]), 200'd0);
    check_val("ovf_cyc3", 200'(ov_q[3]), 200'd1);
    check_val("ovf_held", 200'(overflow), 200'd1);

    // Pop/push collision: full buffer, push on the edge loading beat 7.
    do_reset();
    check_val("coll_ovf_cleared", 200'(overflow), 200'd0);
    exp_q.push_back(make_state(6));
    exp_q.push_back(make_state(7));
    exp_q.push_back(make_state(8));
    step(1'b1, exp_q[0]);
    step(1'b1, exp_q[1]);
    idle(6);
    step(1'b1, exp_q[2]);
    idle(24);
    check_frames("coll", 3, 2);
    check_val("coll_overflow", 200'(overflow), 200'd0);

    // Reset asserted during beat 3.
    do_reset();
    step(1'b1, make_state(9));
    idle(4);
    @(posedge clk);
    #2;
    check_val("mid_ix_before", 200'(doutix), 200'd3);
    check_val("mid_push_before", 200'(pushout), 200'd1);
    reset = 1'b0;
    #1;
    check_val("mid_pushout", 200'(pushout), 200'd0);
    check_val("mid_doutix", 200'(doutix), 200'd0);
    check_val("mid_dout", dout, 200'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    idle(12);
    check_val("mid_quiet", 200'(ix_q.size()), 200'd0);
    check_val("mid_busy", 200'(busy), 200'd0);
    clear_logs();
    exp_q.push_back(make_state(10));
    step(1'b1, exp_q[0]);
    idle(14);
    check_frames("mid_next", 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
